regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- 32-word x 32-bit general-purpose register file for the pipelined CPU, two read ports and one write port.
- Sits directly upstream of the per-port 32:1 word-select multiplexers. Owns the 32x32 storage array that those multiplexers consume, plus write decode, register-0 handling and write-to-read bypass.
- Decode stage reads rs/rt through ports A/B. Writeback stage writes through the W port.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register address width. Depth is 2**ADDR_WIDTH = 32.
- BYPASS_EN, 1, 1 enables write-to-read forwarding in the same cycle; 0 returns stored contents only.

Ports:
- clk  input  1  rising-edge clock for all storage.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write enable from writeback stage.
- wr_addr  input  ADDR_WIDTH  destination register.
- wr_data  input  DATA_WIDTH  write value.
- rd_addr_a  input  ADDR_WIDTH  read port A address (rs).
- rd_addr_b  input  ADDR_WIDTH  read port B address (rt).
- rd_data_a  output  DATA_WIDTH  read port A data.
- rd_data_b  output  DATA_WIDTH  read port B data.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Storage: 32 registers, each DATA_WIDTH bits.
- Reset:
  - rst_n low clears all 32 registers to 0 immediately, independent of clk.
  - While rst_n is low, rd_data_a and rd_data_b read 0.
  - Writes are blocked while rst_n is low.
  - Deassertion takes effect at the next rising edge; the first write is accepted on that edge if wr_en is high.
- Write:
  - On rising clk with rst_n high, wr_en high and wr_addr != 0: reg[wr_addr] <= wr_data.
  - Decode is one-hot (5-to-32). Exactly one register is updated per write.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are discarded. Storage for reg 0 may be omitted or tied to 0.
- Read: purely combinational, with zero cycles of latency. The 32 words feed one 32:1 word-select mux per port, with rd_addr as the select.
- Bypass (BYPASS_EN=1):
  - If wr_en high, wr_addr != 0 and rd_addr_x == wr_addr, rd_data_x = wr_data in the same cycle, before the edge commits.
  - This resolves the writeback/decode hazard without a stall.
  - Ports A and B are bypassed independently. Both may match simultaneously.
- Bypass disabled (BYPASS_EN=0): reads return the stored value. The new value is visible the cycle after the write edge.
- Simultaneous events:
  - Read of address 0 while writing address 0: 0.
  - Both read ports on the same address: identical data.
  - Reset asserted mid-cycle with wr_en high: the write is lost and the register is 0.
- Timing: no X propagation. Unknown addresses must not corrupt other registers. wr_en low means no state change.
- Width rules:
  - No sign extension or truncation. All data paths are DATA_WIDTH.
  - Address compare is a full ADDR_WIDTH equality.

Test Plan:
- Reset: preload regs 1..31 with 0xA5A5_0000+i, pulse rst_n low between edges -> all reads return 0x0000_0000 immediately, and still 0 after rst_n rises.
- Write/read: write 0xDEAD_BEEF to r7 at edge N, set rd_addr_a=7 at N+1 -> rd_data_a=0xDEAD_BEEF. Set rd_addr_b=8 -> 0.
- Register 0: wr_en=1, wr_addr=0, wr_data=0xFFFF_FFFF, with rd_addr_a=0 both in the same cycle and after the edge -> rd_data_a=0 in both.
- Bypass: r3 holds 0x1111_1111. In the same cycle wr_addr=3, wr_data=0x2222_2222, rd_addr_a=rd_addr_b=3 -> both ports read 0x2222_2222 before the edge. With BYPASS_EN=0 -> 0x1111_1111 before the edge, 0x2222_2222 after.
- Full sweep: write r[i]=i*0x0101_0101 for i=1..31, read all pairs via A/B -> exact match. wr_en=0 cycles with random wr_addr/wr_data -> no register changes.
- Reset mid-write: wr_en=1 to r5 with 0x5555_5555, drop rst_n before the edge -> r5 reads 0 after release.

Source files
------------

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//
// General-purpose register file for the pipelined CPU: 2**ADDR_WIDTH words of
// DATA_WIDTH bits, two combinational read ports (decode: rs on A, rt on B)
// and one synchronous write port (writeback).
//
// Register 0 has no storage and always reads zero; writes to it are dropped.
// With BYPASS_EN=1 a write in flight is forwarded to any read port that
// addresses the same register in the same cycle, so decode sees the
// writeback value without a stall.
//
// Ports:
//   clk        rising-edge clock for all storage
//   rst_n      asynchronous active-low reset; clears every register and
//              forces both read ports to zero while low
//   wr_en      write enable from writeback
//   wr_addr    destination register
//   wr_data    value to write
//   rd_addr_a  read port A address (rs)
//   rd_addr_b  read port B address (rt)
//   rd_data_a  read port A data (combinational)
//   rd_data_b  read port B data (combinational)
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Flattened view of all registers, consumed by the two read muxes.
    logic [DATA_WIDTH-1:0] words [DEPTH];

    // A write that actually lands in storage (address 0 is a sink).
    logic wr_fire;
    assign wr_fire = wr_en && (wr_addr != '0);

    // One register per address. Each slot decodes its own address, so the
    // write decode is one-hot by construction: a single full-width equality
    // per register means no other slot can be touched.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign words[gi] = '0;
            end else begin : g_store
                logic                  wr_hit;
                logic [DATA_WIDTH-1:0] word_reg;

                assign wr_hit = wr_en && (wr_addr == ADDR_WIDTH'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        word_reg <= '0;
                    end else if (wr_hit) begin
                        word_reg <= wr_data;
                    end
                end

                assign words[gi] = word_reg;
            end
        end
    endgenerate

    // Read ports: 32:1 word select per port, then optional forwarding of the
    // in-flight write. While reset is held the ports are forced to zero so a
    // blocked write cannot leak through the bypass path.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rst_n) begin
            rd_data_a = words[rd_addr_a];
            rd_data_b = words[rd_addr_b];
            if (BYPASS_EN != 0) begin
                if (wr_fire && (rd_addr_a == wr_addr)) begin
                    rd_data_a = wr_data;
                end
                if (wr_fire && (rd_addr_b == wr_addr)) begin
                    rd_data_b = wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Drives two instances (forwarding on and off) with identical stimulus.
// A driver issues one transaction per clock and pushes the expected read
// data, computed from a plain array model of the register contents, into a
// queue; an independent monitor pops one entry per falling edge and compares
// it with both instances.
// ---------------------------------------------------------------------------
module tb_regfile_2r1w;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [31:0] nb_data_a;
    logic [31:0] nb_data_b;

    regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
    );

    regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_data_a), .rd_data_b(nb_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_nb_a;
        logic [31:0] exp_nb_b;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [32];
    int          checks = 0;
    int          errors = 0;
    bit          stim_done = 0;

    // Expected value of one read port: architectural register contents, with
    // the pending write visible early only when forwarding is on.
    function automatic logic [31:0] model_read(input bit fwd, input bit rst,
                                              input bit we, input logic [4:0] wa,
                                              input logic [31:0] wd,
                                              input logic [4:0] ra);
        if (!rst) return 32'h0;
        if (ra == 5'd0) return 32'h0;
        if (fwd && we && wa == ra) return wd;
        return model_mem[ra];
    endfunction

    // One clock of stimulus. drop_rst asserts reset after the read is
    // sampled but before the next edge, so the pending write must be lost.
    task automatic cycle(input string tag, input bit rst, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input bit drop_rst);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        e.tag      = tag;
        e.ra       = ra;
        e.rb       = rb;
        e.exp_a    = model_read(1, rst, we, wa, wd, ra);
        e.exp_b    = model_read(1, rst, we, wa, wd, rb);
        e.exp_nb_a = model_read(0, rst, we, wa, wd, ra);
        e.exp_nb_b = model_read(0, rst, we, wa, wd, rb);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        if (drop_rst) rst_n = 1'b0;
        if (!rst || drop_rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            model_mem[wa] = wd;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Monitor: the read ports are valid for the whole second half of each
    // cycle; one queued transaction is retired per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_a"},    rd_data_a, e.exp_a);
            check({e.tag, "_b"},    rd_data_b, e.exp_b);
            check({e.tag, "_nb_a"}, nb_data_a, e.exp_nb_a);
            check({e.tag, "_nb_b"}, nb_data_b, e.exp_nb_b);
            $display("txn %-8s ra=%0d rb=%0d a=%08h b=%08h nb_a=%08h nb_b=%08h",
                     e.tag, e.ra, e.rb, rd_data_a, rd_data_b, nb_data_a, nb_data_b);
        end
    end

    initial begin
        logic [4:0]  wa;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] wd;
        bit          we;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;

        // Reset state, with a write attempt that must be blocked.
        cycle("rst", 0, 1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd1, 0);
        cycle("rst", 0, 0, 5'd0, 32'h0, 5'd31, 5'd0, 0);

        // Preload, then reset pulse between edges.
        for (int i = 1; i < 32; i++)
            cycle("preload", 1, 1, 5'(i), 32'hA5A5_0000 + 32'(i), 5'(i), 5'(i - 1), 0);
        cycle("rstpulse", 0, 1, 5'd4, 32'h1234_5678, 5'd4, 5'd17, 0);
        for (int i = 0; i < 32; i += 2)
            cycle("postrst", 1, 0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 0);

        // Basic write then read.
        cycle("wr7", 1, 1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0, 0);
        cycle("rd7", 1, 0, 5'd0, 32'h0, 5'd7, 5'd8, 0);

        // Register 0 is never written.
        cycle("r0", 1, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 0);
        cycle("r0post", 1, 0, 5'd0, 32'h0, 5'd0, 5'd7, 0);

        // Forwarding: both ports hit the in-flight write.
        cycle("byp_pre", 1, 1, 5'd3, 32'h1111_1111, 5'd1, 5'd2, 0);
        cycle("byp", 1, 1, 5'd3, 32'h2222_2222, 5'd3, 5'd3, 0);
        cycle("byp_post", 1, 0, 5'd0, 32'h0, 5'd3, 5'd3, 0);

        // Full sweep, then idle cycles with random junk on the write port.
        for (int i = 1; i < 32; i++)
            cycle("sweep_w", 1, 1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(i), 0);
        for (int i = 0; i < 32; i++) begin
            wa = 5'($urandom_range(31, 0));
            wd = $urandom;
            cycle("idle", 1, 0, wa, wd, 5'(i), 5'(31 - i), 0);
        end

        // Random traffic with frequent read/write address collisions.
        for (int n = 0; n < 300; n++) begin
            we = ($urandom_range(3, 0) != 0);
            wa = 5'($urandom_range(31, 0));
            if ($urandom_range(7, 0) == 0) wa = 5'd0;
            wd = $urandom;
            ra = ($urandom_range(2, 0) == 0) ? wa : 5'($urandom_range(31, 0));
            rb = ($urandom_range(2, 0) == 0) ? wa : 5'($urandom_range(31, 0));
            cycle("rand", 1, we, wa, wd, ra, rb, 0);
        end

        // Reset dropped after the write is presented but before its edge.
        cycle("midw", 1, 1, 5'd5, 32'h5555_5555, 5'd5, 5'd6, 1);
        cycle("midw_rel", 1, 0, 5'd0, 32'h0, 5'd5, 5'd6, 0);

        stim_done = 1;
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        if (!stim_done) begin
            errors++;
            $display("FAIL timeout got=running expected=done");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
